// File: rtl/pac_man_pkg.sv
// Shared definitions for the Pac-Man movement blocks.
// Holds the maze geometry, the reset position, the tunnel row, the default
// pacing period, the block index type and the executor state encoding.
package pac_man_pkg;

  localparam int GRID_COLS   = 32;
  localparam int GRID_ROWS   = 24;
  localparam int NUM_BLOCKS  = GRID_COLS * GRID_ROWS;
  localparam int START_BLOCK = 495;  // row 15, col 15
  localparam int TUNNEL_ROW  = 14;
  localparam int MOVE_PERIOD = 8;

  typedef logic [9:0] block_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    CHECK  = 2'd2
  } exec_state_t;

endpackage

// File: rtl/pac_man_move_executor_if.sv
// Bundle of the move executor's request, wall-memory and status signals.
//   next_block/next_valid/next_ready : move request handshake
//   wall_addr/wall_data              : synchronous wall memory read port
//   curr_block/moved/blocked         : committed position and outcome pulses
// modport slave  : the executor itself.
// modport master : its environment (behaviour block, wall memory, renderer).
interface pac_man_move_executor_if;
  import pac_man_pkg::*;

  block_t next_block;
  logic   next_valid;
  logic   next_ready;
  block_t wall_addr;
  logic   wall_data;
  block_t curr_block;
  logic   moved;
  logic   blocked;

  modport slave (
    input  next_block, next_valid, wall_data,
    output next_ready, wall_addr, curr_block, moved, blocked
  );

  modport master (
    output next_block, next_valid, wall_data,
    input  next_ready, wall_addr, curr_block, moved, blocked
  );

endinterface

// File: rtl/pac_man_move_timer.sv
// Saturating pacing counter.
//   clk   : system clock
//   reset : synchronous, active-low; counter returns to 0
//   clr   : restart the count from 0 (takes priority over counting)
//   due   : high while the counter sits at PERIOD-1
// Also used to pace the ghosts.
module pac_man_move_timer #(
  parameter int PERIOD = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic due
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt_reg, cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (cnt_reg != LAST) begin
      cnt_next = cnt_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign due = (cnt_reg == LAST);

endmodule

// File: rtl/pac_man_move_executor.sv
// Commits Pac-Man's requested moves on the maze grid.
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : slave side of pac_man_move_executor_if
//           (request handshake, wall memory read port, position and pulses)
// A request is accepted only when the pacing timer is due and the executor
// is idle. Out-of-range or non-adjacent targets are rejected straight away;
// adjacent targets are looked up in the wall memory (one-cycle read latency)
// and committed only if the target block is open.
module pac_man_move_executor #(
  parameter int COLS        = pac_man_pkg::GRID_COLS,
  parameter int ROWS        = pac_man_pkg::GRID_ROWS,
  parameter int START_BLOCK = pac_man_pkg::START_BLOCK,
  parameter int TUNNEL_ROW  = pac_man_pkg::TUNNEL_ROW,
  parameter int MOVE_PERIOD = pac_man_pkg::MOVE_PERIOD
) (
  input logic                     clk,
  input logic                     reset,
  pac_man_move_executor_if.slave  bus
);
  import pac_man_pkg::*;

  localparam int         NUM      = COLS * ROWS;
  localparam logic [10:0] NUM_W   = 11'(NUM);  // 11 bits so NUM == 1024 fits
  localparam block_t     COLS_B   = block_t'(COLS);
  localparam block_t     START_B  = block_t'(START_BLOCK);
  localparam block_t     TROW_B   = block_t'(TUNNEL_ROW);
  localparam block_t     LASTCOL_B = block_t'(COLS - 1);

  exec_state_t state_reg, state_next;
  block_t      req_reg;
  block_t      curr_reg;
  logic        blocked_reg;

  logic   due;
  logic   ready;
  logic   accept;
  logic   in_range, same, adjacent, legal_move, illegal;
  block_t nrow, ncol, crow, ccol;

  // Constant divisors: these reduce to bit slices when COLS is a power of two.
  assign nrow = bus.next_block / COLS_B;
  assign ncol = bus.next_block % COLS_B;
  assign crow = curr_reg / COLS_B;
  assign ccol = curr_reg % COLS_B;

  assign in_range = ({1'b0, bus.next_block} < NUM_W);
  assign same     = (bus.next_block == curr_reg);
  assign adjacent =
      ((nrow == crow) && ((ncol == ccol + block_t'(1)) || (ccol == ncol + block_t'(1)))) ||
      ((ncol == ccol) && ((nrow == crow + block_t'(1)) || (crow == nrow + block_t'(1)))) ||
      ((nrow == crow) && (nrow == TROW_B) &&
       (((ncol == '0) && (ccol == LASTCOL_B)) || ((ncol == LASTCOL_B) && (ccol == '0))));

  // Same-block requests are accepted as no-ops, so they are neither a move
  // nor a rejection.
  assign legal_move = in_range && !same && adjacent;
  assign illegal    = !in_range || (!same && !adjacent);

  assign ready  = (state_reg == IDLE) && due;
  assign accept = bus.next_valid && ready;

  pac_man_move_timer #(
    .PERIOD (MOVE_PERIOD)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .due   (due)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && legal_move) state_next = LOOKUP;
      LOOKUP:  state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. The wall memory is pointed at the current block except
  // while a lookup is in flight, so wall_data in CHECK belongs to req_reg.
  always_comb begin
    bus.next_ready = ready;
    bus.curr_block = curr_reg;
    bus.wall_addr  = (state_reg == LOOKUP) ? req_reg : curr_reg;
    bus.moved      = (state_reg == CHECK) && !bus.wall_data;
    bus.blocked    = blocked_reg || ((state_reg == CHECK) && bus.wall_data);
  end

  // Datapath registers. blocked_reg can only be set from IDLE, so it is
  // always clear during CHECK and the two pulses never overlap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      curr_reg    <= START_B;
      req_reg     <= START_B;
      blocked_reg <= 1'b0;
    end else begin
      blocked_reg <= accept && illegal;
      if (accept) begin
        req_reg <= bus.next_block;
      end
      if ((state_reg == CHECK) && !bus.wall_data) begin
        curr_reg <= req_reg;
      end
    end
  end

endmodule

// File: tb/tb_pac_man_move_executor.sv
module tb_pac_man_move_executor;
  import pac_man_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pac_man_move_executor_if bus ();

  pac_man_move_executor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous wall memory: data follows the address by one clock.
  logic wall_mem [0:1023];
  always @(posedge clk) bus.wall_data <= wall_mem[bus.wall_addr];

  int total = 0;
  int bad = 0;
  int exp_curr = 495;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: 0 = no-op, 1 = illegal, 2 = needs wall lookup
  function automatic int classify(input int cur, input int tgt);
    int cr, cc, tr, tc, dr, dc;
    if (tgt >= 32 * 24) return 1;
    if (tgt == cur) return 0;
    cr = cur / 32; cc = cur % 32;
    tr = tgt / 32; tc = tgt % 32;
    dr = (cr > tr) ? cr - tr : tr - cr;
    dc = (cc > tc) ? cc - tc : tc - cc;
    if (cr == tr && dc == 1) return 2;
    if (cc == tc && dr == 1) return 2;
    if (cr == tr && cr == 14 && dc == 31) return 2;
    return 1;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.next_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_ready_timeout"}, 32'(n < 50), 1);
  endtask

  task automatic do_req(input int tgt, input string tag);
    int kind;
    logic w;
    wait_ready(tag);
    bus.next_block = 10'(tgt);
    bus.next_valid = 1'b1;
    tick();
    bus.next_valid = 1'b0;
    kind = classify(exp_curr, tgt);
    if (kind == 0) begin
      $display("txn %s: %0d -> %0d no-op", tag, exp_curr, tgt);
      chk({tag, "_noop_moved"}, bus.moved, 0);
      chk({tag, "_noop_blocked"}, bus.blocked, 0);
      chk({tag, "_noop_ready"}, bus.next_ready, 0);
      chk({tag, "_noop_curr"}, bus.curr_block, exp_curr);
    end else if (kind == 1) begin
      $display("txn %s: %0d -> %0d illegal", tag, exp_curr, tgt);
      chk({tag, "_ill_blocked"}, bus.blocked, 1);
      chk({tag, "_ill_moved"}, bus.moved, 0);
      chk({tag, "_ill_addr"}, bus.wall_addr, exp_curr);
      tick();
      chk({tag, "_ill_blocked_end"}, bus.blocked, 0);
      chk({tag, "_ill_curr"}, bus.curr_block, exp_curr);
    end else begin
      w = wall_mem[tgt];
      $display("txn %s: %0d -> %0d lookup wall=%0d", tag, exp_curr, tgt, w);
      chk({tag, "_addr"}, bus.wall_addr, tgt);
      chk({tag, "_early_moved"}, bus.moved, 0);
      tick();
      chk({tag, "_moved"}, bus.moved, 32'(!w));
      chk({tag, "_blocked"}, bus.blocked, 32'(w));
      chk({tag, "_curr_hold"}, bus.curr_block, exp_curr);
      tick();
      if (!w) exp_curr = tgt;
      chk({tag, "_curr"}, bus.curr_block, exp_curr);
      chk({tag, "_pulse_end"}, bus.moved | bus.blocked, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, last, nxt, r, tgt, row, col;
    bus.next_valid = 1'b0;
    bus.next_block = '0;
    for (int i = 0; i < 1024; i++) wall_mem[i] = 1'b0;

    // Reset values
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_curr", bus.curr_block, 495);
    chk("rst_addr", bus.wall_addr, 495);
    chk("rst_ready", bus.next_ready, 0);
    chk("rst_moved", bus.moved, 0);
    chk("rst_blocked", bus.blocked, 0);
    reset = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("rst_ready_c%0d", k), bus.next_ready, 32'(k == 7));
    end
    exp_curr = 495;

    // Directed moves
    do_req(496, "move_right");
    do_req(495, "move_left");
    wall_mem[463] = 1'b1;
    do_req(463, "wall_up");
    wall_mem[463] = 1'b0;
    do_req(500, "non_adjacent");
    do_req(800, "out_of_range");
    do_req(495, "same_block");

    // Held next_valid with a legal chain: accepts every MOVE_PERIOD cycles
    wait_ready("chain");
    acc = 0; last = -1; nxt = 496;
    bus.next_block = 10'(nxt);
    bus.next_valid = 1'b1;
    for (int n = 0; n < 100 && acc < 3; n++) begin
      logic pr;
      pr = bus.next_ready;
      tick();
      if (pr) begin
        acc++;
        if (last >= 0) chk("chain_gap", 32'(n - last), MOVE_PERIOD);
        last = n;
        nxt++;
        bus.next_block = 10'(nxt);
      end
    end
    bus.next_valid = 1'b0;
    chk("chain_count", 32'(acc), 3);
    repeat (3) tick();
    chk("chain_curr", bus.curr_block, 498);
    $display("txn chain: 495 -> 498 accepts=%0d", acc);
    exp_curr = 498;

    // Reset during CHECK discards the move
    wait_ready("rst_check");
    bus.next_block = 10'd497;
    bus.next_valid = 1'b1;
    tick();
    bus.next_valid = 1'b0;
    tick();
    chk("rst_check_moved", bus.moved, 1);
    reset = 1'b0;
    tick();
    chk("rst_check_curr", bus.curr_block, 495);
    chk("rst_check_moved_clr", bus.moved, 0);
    reset = 1'b1;
    exp_curr = 495;
    $display("txn rst_check: 498 -> 497 discarded, curr=495");

    // Walk to the tunnel row, wrap, then try a row-edge step
    do_req(463, "to_row14");
    for (int c = 14; c >= 0; c--) do_req(448 + c, "walk_left");
    do_req(479, "tunnel_wrap");
    do_req(448, "tunnel_back");
    do_req(480, "step_down");
    do_req(479, "row_edge");

    // Randomised walk over a random maze
    for (int i = 0; i < 1024; i++) wall_mem[i] = ($urandom_range(0, 3) == 0);
    for (int t = 0; t < 150; t++) begin
      repeat ($urandom_range(0, 4)) tick();
      r = $urandom_range(0, 9);
      row = exp_curr / 32;
      col = exp_curr % 32;
      case (r)
        0, 1: tgt = (exp_curr + 1) % 1024;
        2, 3: tgt = (exp_curr + 1023) % 1024;
        4:    tgt = (exp_curr + 32) % 1024;
        5:    tgt = (exp_curr + 1024 - 32) % 1024;
        6:    tgt = $urandom_range(0, 767);
        7:    tgt = $urandom_range(768, 1023);
        8:    tgt = exp_curr;
        default: begin
          if (row == 14 && col == 0) tgt = exp_curr + 31;
          else if (row == 14 && col == 31) tgt = exp_curr - 31;
          else tgt = 14 * 32 + (($urandom_range(0, 1) == 0) ? 0 : 31);
        end
      endcase
      do_req(tgt, $sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pac_man_move_executor.md
# pac_man_move_executor

Commits Pac-Man's requested moves on the 32×24 maze grid. It accepts a requested `next_block` from `pac_man_behavior`, paces moves with a move-rate timer, and rejects illegal moves: out-of-range, non-adjacent, or wall. It checks walls against the synchronous maze wall memory and owns the authoritative `curr_block` register that feeds back to `pac_man_behavior` and to the renderer.

## Interface
Parameters:
- `COLS`, 32, grid columns.
- `ROWS`, 24, grid rows. `COLS*ROWS` must be ≤ 1024.
- `START_BLOCK`, 495, block index loaded on reset (row 15, col 15).
- `TUNNEL_ROW`, 14, the only row where col 0 ↔ col `COLS-1` wrap is legal.
- `MOVE_PERIOD`, 8, minimum cycles between accepted requests. Must be ≥ 4.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-low. Asserted when 0, sampled on the rising edge of `clk`.
- `next_block` in 10: requested destination block.
- `next_valid` in 1: request present.
- `next_ready` out 1: executor can accept a request this cycle.
- `wall_addr` out 10: wall memory read address.
- `wall_data` in 1: wall bit, valid one cycle after `wall_addr`. 1 = wall.
- `curr_block` out 10: committed Pac-Man position.
- `moved` out 1: one-cycle pulse when a move commits.
- `blocked` out 1: one-cycle pulse when a request is rejected.

## Operation
- States: `IDLE` → `LOOKUP` → `CHECK` → `IDLE`.
- Move timer `tmr`:
  - Counts up each cycle and saturates at `MOVE_PERIOD-1`.
  - Clears to 0 on every accepted request.
- `next_ready` = (state == `IDLE`) && (`tmr` == `MOVE_PERIOD-1`).
- A request is accepted when `next_valid && next_ready`. The request is latched into `req`.
- Legality check at acceptance (combinational on `next_block`):
  - `next_block` ≥ `COLS*ROWS` → illegal.
  - `next_block` == `curr_block` → no-op. Accepted; no lookup, no pulse, state stays `IDLE`.
  - Adjacent means one of:
    - same row and column differs by 1;
    - same column and row differs by 1;
    - row == `TUNNEL_ROW` and columns are {0, `COLS-1`}.
  - Anything else is illegal.
  - Illegal request → `blocked` pulses the next cycle; state stays `IDLE`; no lookup.
- Legal request → go to `LOOKUP`. `wall_addr` = `req` in `LOOKUP`.
- `CHECK` samples `wall_data`:
  - 0 → `curr_block` ← `req`, `moved` = 1.
  - 1 → `blocked` = 1, `curr_block` unchanged.
- In `CHECK`, `moved` or `blocked` is asserted combinationally and the state returns to `IDLE`.
- `wall_addr` = `curr_block` whenever the state is not `LOOKUP`.
- Row = index / `COLS` and column = index % `COLS`. With `COLS` a power of two these are bit slices; the general case uses constant division.

## Timing
- Reset values:
  - `curr_block` = `START_BLOCK`
  - state `IDLE`, `tmr` = 0
  - `next_ready` = 0, `moved` = 0, `blocked` = 0
  - `wall_addr` = `START_BLOCK`
- First possible acceptance is `MOVE_PERIOD-1` cycles after reset is released.
- Legal move accepted at edge N:
  - `wall_addr` = `req` during cycle N+1;
  - `wall_data` is valid and `moved`/`blocked` is high during cycle N+2;
  - `curr_block` shows the new value after edge N+3.
- Illegal request accepted at edge N: `blocked` is high during cycle N+1.
- Back-to-back requests are accepted exactly every `MOVE_PERIOD` cycles.
- `next_valid` held while `next_ready` = 0 has no effect; requests are not queued.
- `curr_block` changes only when `moved` fires.
- A `reset` asserted (low) in any state returns all registers to reset values at that edge. An in-flight move is discarded and `curr_block` = `START_BLOCK`.
- `moved` and `blocked` are never high in the same cycle.

## Structure
- Package `pac_man_pkg` holds:
  - `GRID_COLS`, `GRID_ROWS`, `NUM_BLOCKS`, `START_BLOCK`, `TUNNEL_ROW`;
  - typedef `block_t` (`logic [9:0]`);
  - enum `exec_state_t`.
- Sub-module `pac_man_move_timer`: a saturating counter with a clear input and a `due` output. It is reused for ghost pacing.

## Test plan
- Reset, hold `next_valid` = 0 → `curr_block` = 495, `next_ready` first rises 7 cycles after release.
- Request 496, wall memory at 496 = 0 → `wall_addr` = 496 one cycle after acceptance, `moved` two cycles after, `curr_block` = 496 three cycles after.
- From 495 request 463, wall memory at 463 = 1 → `blocked` pulse, `curr_block` stays 495, `moved` never rises.
- From 495 request 500 (non-adjacent) or 800 (out of range) → `blocked` the next cycle, `wall_addr` never equals the request.
- Tunnel and row-edge moves:
  - From 448 (row 14, col 0) request 479 → moves to 479.
  - From 480 (row 15, col 0) request 479 → `blocked` (row change via ±1).
- `next_valid` held high with a legal chain 495→496→497→498 → acceptances exactly 8 cycles apart.
- Assert `reset` low in the `CHECK` cycle of a legal move → no commit; `curr_block` = 495 the next cycle.
